uart_tx_fifo: RTL

Buffered, runtime-configurable UART transmitter. It is the next generation of the fixed 8N1 edge-triggered transmitter. It accepts bytes over a valid/ready handshake into an internal FIFO and serialises them back-to-back with no idle gap. Frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and the bit period are set at runtime. It sits between the CPU/peripheral bus glue and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime frame format and baud divisor
module uart_tx_fifo #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [1:0]       data_bits_i,
    input  logic [1:0]       parity_i,
    input  logic             two_stop_i,
    output logic [FIFO_AW:0] fifo_level_o,
    output logic             busy_o,
    output logic             tx_done_o,
    output logic             uart_tx_o
);
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(2**FIFO_AW);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic [7:0]         mem_q [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_AW:0]   count_q, count_d;
    state_t             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d, tick_q, tick_d, div_eff;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         nbits_q, nbits_d, par_q, par_d;
    logic               two_q, two_d, stop2_q, stop2_d, acc_q, acc_d;
    logic               tx_q, tx_d, done_q, done_d, busy_q, busy_d;
    logic               push, pop, last, par_en, frame_end;
    assign tx_ready_o   = count_q != FULL;
    assign fifo_level_o = count_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;
    assign uart_tx_o    = tx_q;
    assign push      = tx_valid_i & tx_ready_o;
    assign div_eff   = baud_div_i < DIV_W'(2) ? DIV_W'(2) : baud_div_i;
    assign last      = tick_q == '0;
    assign par_en    = par_q[0] ^ par_q[1];
    assign frame_end = state_q == STOP && last && (!two_q || stop2_q);
    assign pop       = count_q != '0 && (state_q == IDLE || frame_end);
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        tick_d  = state_q == IDLE ? tick_q : last ? div_q - DIV_W'(1) : tick_q - DIV_W'(1);
        bit_d   = bit_q;
        nbits_d = nbits_q;
        par_d   = par_q;
        two_d   = two_q;
        stop2_d = stop2_q;
        acc_d   = acc_q;
        case (state_q)
            START:   if (last) state_d = DATA;
            DATA:    if (last) begin
                shift_d = shift_q >> 1;
                acc_d   = acc_q ^ shift_q[0];
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd4 + {1'b0, nbits_q}) state_d = par_en ? PARITY : STOP;
            end
            PARITY:  if (last) state_d = STOP;
            STOP:    if (last) begin
                if (two_q && !stop2_q) stop2_d = 1'b1;
                else state_d = IDLE;
            end
            default: ;
        endcase
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_q];
            div_d   = div_eff;
            tick_d  = div_eff - DIV_W'(1);
            bit_d   = '0;
            nbits_d = data_bits_i;
            par_d   = parity_i;
            two_d   = two_stop_i;
            stop2_d = 1'b0;
            acc_d   = 1'b0;
        end
        tx_d    = state_q == START  ? 1'b0 :
                  state_q == DATA   ? shift_q[0] :
                  state_q == PARITY ? acc_q ^ par_q[1] : 1'b1;
        done_d  = frame_end;
        busy_d  = state_q != IDLE;
        wr_d    = wr_q + FIFO_AW'(push);
        rd_d    = rd_q + FIFO_AW'(pop);
        count_d = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) mem_q[wr_q] <= tx_data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            shift_q <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            par_q   <= '0;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            acc_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            par_q   <= par_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            acc_q   <= acc_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
endmodule
